hamming_codec_arbiter: RTL and testbench

- Sequencer and round-robin arbiter sharing one Hamming codec (4-bit encode / 8-bit SECDED decode) between two requesters.
- Accepts a job through a valid/ready handshake, drives the codec operands and mode, waits the codec latency, then returns the result and status to the owning requester.
- Sits between the tile's I/O front end and the combinational or pipelined codec datapath.

---
 rtl/hamming_codec_arbiter.sv | 146 ++++++++++++++
 tb/tb_hamming_codec_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_codec_arbiter.sv
// Round-robin sequencer sharing one Hamming codec between two requesters; result returned CODEC_LAT+1 cycles after accept.
// Optional HAMMING_ARB_STATS_EN adds saturating single/double error counters for decode jobs.
module hamming_codec_arbiter #(
    parameter int CODEC_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [1:0] req_mode,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] resp_valid,
    input  logic [1:0] resp_ready,
    output logic [7:0] resp_data,
    output logic [4:0] resp_status,
    output logic       codec_mode,
    output logic [7:0] codec_data,
    input  logic [7:0] codec_result,
    input  logic [2:0] codec_syndrome,
    input  logic [1:0] codec_err,
`ifdef HAMMING_ARB_STATS_EN
    input  logic       stat_clr,
    output logic [7:0] stat_single,
    output logic [7:0] stat_double,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       owner_q, owner_d;
    logic       mode_q, mode_d;
    logic [7:0] data_q, data_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] resp_data_q, resp_data_d;
    logic [4:0] resp_status_q, resp_status_d;

    logic       winner;
    logic [7:0] operand;
    logic       capture;

    // With both requesters pending the pointer decides; otherwise the lone requester wins.
    assign winner  = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
    assign operand = winner ? req_data1 : req_data0;
    assign capture = (state_q == WAIT) && (cnt_q == 3'd1);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        mode_d        = mode_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        resp_data_d   = resp_data_q;
        resp_status_d = resp_status_q;
        req_ready     = 2'b00;
        resp_valid    = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[winner] = 1'b1;
                    owner_d           = winner;
                    mode_d            = req_mode[winner];
                    data_d            = req_mode[winner] ? operand : {4'b0000, operand[3:0]};
                    cnt_d             = 3'(CODEC_LAT);
                    state_d           = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    resp_data_d   = codec_result;
                    resp_status_d = mode_q ? {codec_syndrome, codec_err} : 5'b00000;
                    state_d       = RESP;
                end
            end
            RESP: begin
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    rr_ptr_d = ~owner_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 1'b0;
            owner_q       <= 1'b0;
            mode_q        <= 1'b0;
            data_q        <= 8'h00;
            cnt_q         <= 3'd0;
            resp_data_q   <= 8'h00;
            resp_status_q <= 5'b00000;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            mode_q        <= mode_d;
            data_q        <= data_d;
            cnt_q         <= cnt_d;
            resp_data_q   <= resp_data_d;
            resp_status_q <= resp_status_d;
        end
    end

    assign codec_mode  = mode_q;
    assign codec_data  = data_q;
    assign resp_data   = resp_data_q;
    assign resp_status = resp_status_q;
    assign busy        = (state_q != IDLE);

`ifdef HAMMING_ARB_STATS_EN
    logic [7:0] stat_single_q, stat_double_q;

    // Reserved err=11 is counted as a double error.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_single_q <= 8'h00;
            stat_double_q <= 8'h00;
        end else if (capture && mode_q) begin
            if ((codec_err == 2'b01) && (stat_single_q != 8'hFF))
                stat_single_q <= stat_single_q + 8'h01;
            if (codec_err[1] && (stat_double_q != 8'hFF))
                stat_double_q <= stat_double_q + 8'h01;
        end
    end

    assign stat_single = stat_single_q;
    assign stat_double = stat_double_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_hamming_codec_arbiter.sv
// Bench for hamming_codec_arbiter: vector table, directed corner sequences and a randomized
// run against a transaction-level model; a second instance with CODEC_LAT=3 covers reset mid-WAIT.
module tb_hamming_codec_arbiter;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] req_valid, req_mode, resp_ready;
    logic [7:0] req_data0, req_data1;
    logic       stat_clr;

    logic [1:0] req_ready, resp_valid;
    logic [7:0] resp_data, codec_data, codec_result;
    logic [4:0] resp_status;
    logic       codec_mode, busy;
    logic [2:0] codec_syndrome;
    logic [1:0] codec_err;

    logic [1:0] req_ready_3, resp_valid_3;
    logic [7:0] resp_data_3, codec_data_3, codec_result_3;
    logic [4:0] resp_status_3;
    logic       codec_mode_3, busy_3;
    logic [2:0] codec_syndrome_3;
    logic [1:0] codec_err_3;
`ifdef HAMMING_ARB_STATS_EN
    logic [7:0] stat_single, stat_double, stat_single_3, stat_double_3;
`endif

    // Codec stubs
    assign codec_result     = codec_data ^ 8'hFF;
    assign codec_syndrome   = codec_data[2:0];
    assign codec_err        = codec_data[4:3];
    assign codec_result_3   = codec_data_3 ^ 8'hFF;
    assign codec_syndrome_3 = codec_data_3[2:0];
    assign codec_err_3      = codec_data_3[4:3];

    hamming_codec_arbiter #(.CODEC_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_status(resp_status), .codec_mode(codec_mode), .codec_data(codec_data),
        .codec_result(codec_result), .codec_syndrome(codec_syndrome), .codec_err(codec_err),
`ifdef HAMMING_ARB_STATS_EN
        .stat_clr(stat_clr), .stat_single(stat_single), .stat_double(stat_double),
`endif
        .busy(busy)
    );

    hamming_codec_arbiter #(.CODEC_LAT(LAT3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_3),
        .req_mode(req_mode), .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid_3), .resp_ready(resp_ready), .resp_data(resp_data_3),
        .resp_status(resp_status_3), .codec_mode(codec_mode_3), .codec_data(codec_data_3),
        .codec_result(codec_result_3), .codec_syndrome(codec_syndrome_3), .codec_err(codec_err_3),
`ifdef HAMMING_ARB_STATS_EN
        .stat_clr(stat_clr), .stat_single(stat_single_3), .stat_double(stat_double_3),
`endif
        .busy(busy_3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        stat_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] rv;
        logic [1:0] mode;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_rdy;
        logic [7:0] exp_cd;
        logic       exp_cm;
        logic [7:0] exp_data;
        logic [4:0] exp_st;
    } vec_t;

    vec_t tbl[6];

    // Transaction-level reference model state
    logic       m_act, m_ptr, m_own, m_cm, w;
    logic [7:0] m_op, m_cd, m_res, m_last_d;
    logic [4:0] m_st, m_last_s;
    int         m_at;

`ifdef HAMMING_ARB_STATS_EN
    task automatic run_jobs(input int n, input logic [7:0] d);
        int cnt;
        cnt = 0;
        req_valid = 2'b01;
        req_mode = 2'b01;
        req_data0 = d;
        resp_ready = 2'b11;
        for (int c = 0; c < n * (LAT + 2) + 20; c++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) cnt++;
            if (cnt == n) break;
            tick();
        end
        tick();
        req_valid = 2'b00;
        chk("stats_job_count", 32'(cnt), 32'(n));
    endtask
`endif

    initial begin
        int n, g;
        logic [1:0] grants[4];
        logic [1:0] e_rdy, e_rv;

        rst = 1'b1;
        req_valid = 2'b00; req_mode = 2'b00; resp_ready = 2'b00;
        req_data0 = 8'h00; req_data1 = 8'h00; stat_clr = 1'b0;

        tbl[0] = '{2'b01, 2'b00, 8'hFB, 8'h00, 2'b01, 8'h0B, 1'b0, 8'hF4, 5'h00};
        tbl[1] = '{2'b10, 2'b10, 8'h00, 8'h0D, 2'b10, 8'h0D, 1'b1, 8'hF2, 5'h15};
        tbl[2] = '{2'b01, 2'b01, 8'h18, 8'h00, 2'b01, 8'h18, 1'b1, 8'hE7, 5'h03};
        tbl[3] = '{2'b10, 2'b00, 8'h00, 8'hA5, 2'b10, 8'h05, 1'b0, 8'hFA, 5'h00};
        tbl[4] = '{2'b11, 2'b01, 8'h37, 8'hC3, 2'b01, 8'h37, 1'b1, 8'hC8, 5'h1E};
        tbl[5] = '{2'b11, 2'b10, 8'h55, 8'h0A, 2'b10, 8'h0A, 1'b1, 8'hF5, 5'h09};

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        chk("rst_resp_status", 32'(resp_status), 0);
        chk("rst_codec_mode", 32'(codec_mode), 0);
        chk("rst_codec_data", 32'(codec_data), 0);
        chk("rst_busy", 32'(busy), 0);

        // Vector table, one job each with resp_ready held high
        for (int i = 0; i < 6; i++) begin
            tick();
            req_valid = tbl[i].rv; req_mode = tbl[i].mode;
            req_data0 = tbl[i].d0; req_data1 = tbl[i].d1; resp_ready = 2'b11;
            @(negedge clk);
            chk("tbl_grant", 32'(req_ready), 32'(tbl[i].exp_rdy));
            tick();
            req_valid = 2'b00;
            @(negedge clk);
            chk("tbl_codec_data", 32'(codec_data), 32'(tbl[i].exp_cd));
            chk("tbl_codec_mode", 32'(codec_mode), 32'(tbl[i].exp_cm));
            chk("tbl_busy", 32'(busy), 1);
            n = 1;
            while (resp_valid == 2'b00 && n < 20) begin
                tick();
                @(negedge clk);
                n++;
            end
            chk("tbl_latency", 32'(n), 32'(1 + LAT));
            chk("tbl_resp_valid", 32'(resp_valid), 32'(tbl[i].exp_rdy));
            chk("tbl_resp_data", 32'(resp_data), 32'(tbl[i].exp_data));
            chk("tbl_resp_status", 32'(resp_status), 32'(tbl[i].exp_st));
            tick();
            @(negedge clk);
            chk("tbl_done_valid", 32'(resp_valid), 0);
            chk("tbl_done_busy", 32'(busy), 0);
            chk("tbl_hold_data", 32'(resp_data), 32'(tbl[i].exp_data));
            chk("tbl_hold_codec", 32'(codec_data), 32'(tbl[i].exp_cd));
        end

        // Contention: both requesters valid every cycle
        do_reset();
        req_valid = 2'b11; req_mode = 2'b00; req_data0 = 8'h01; req_data1 = 8'h02;
        resp_ready = 2'b11;
        g = 0;
        for (int c = 0; c < 40 && g < 4; c++) begin
            @(negedge clk);
            chk("cont_ready_onehot", 32'(req_ready == 2'b11), 0);
            if (req_ready != 2'b00) begin
                grants[g] = req_ready;
                g++;
            end
            tick();
        end
        req_valid = 2'b00;
        chk("cont_jobs", 32'(g), 4);
        for (int k = 0; k < g; k++)
            chk("cont_grant_order", 32'(grants[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
        for (int c = 0; c < LAT + 3; c++) tick();

        // Backpressure in RESP; non-owner resp_ready ignored
        do_reset();
        req_valid = 2'b01; req_mode = 2'b00; req_data0 = 8'h3C; req_data1 = 8'h44;
        resp_ready = 2'b00;
        @(negedge clk);
        chk("bp_grant", 32'(req_ready), 1);
        tick();
        req_valid = 2'b10;
        @(negedge clk);
        n = 0;
        while (resp_valid == 2'b00 && n < 10) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("bp_resp_valid", 32'(resp_valid), 1);
        resp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            chk("bp_hold_valid", 32'(resp_valid), 1);
            chk("bp_hold_data", 32'(resp_data), 32'h F3);
            chk("bp_hold_status", 32'(resp_status), 0);
            chk("bp_busy", 32'(busy), 1);
            chk("bp_no_accept", 32'(req_ready), 0);
        end
        tick();
        resp_ready = 2'b01;
        @(negedge clk);
        chk("bp_last_valid", 32'(resp_valid), 1);
        chk("bp_last_no_accept", 32'(req_ready), 0);
        tick();
        resp_ready = 2'b00;
        @(negedge clk);
        chk("bp_after_valid", 32'(resp_valid), 0);
        chk("bp_after_accept", 32'(req_ready), 2);
        tick();
        req_valid = 2'b00; resp_ready = 2'b11;
        for (int c = 0; c < LAT + 3; c++) tick();

        // Reset mid-WAIT on the CODEC_LAT=3 instance
        do_reset();
        req_valid = 2'b01; req_mode = 2'b00; req_data0 = 8'h12; resp_ready = 2'b11;
        @(negedge clk);
        chk("rw_first_grant", 32'(req_ready_3), 1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n = 0;
        while (resp_valid_3 == 2'b00 && n < 10) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("rw_first_latency", 32'(n), 32'(LAT3));
        tick();
        req_valid = 2'b11; req_mode = 2'b10; req_data1 = 8'h0D;
        @(negedge clk);
        chk("rw_ptr_grant", 32'(req_ready_3), 2);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("rw_busy_wait", 32'(busy_3), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rw_req_ready", 32'(req_ready_3), 0);
        chk("rw_resp_valid", 32'(resp_valid_3), 0);
        chk("rw_resp_data", 32'(resp_data_3), 0);
        chk("rw_resp_status", 32'(resp_status_3), 0);
        chk("rw_codec_mode", 32'(codec_mode_3), 0);
        chk("rw_codec_data", 32'(codec_data_3), 0);
        chk("rw_busy", 32'(busy_3), 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            chk("rw_no_resp", 32'(resp_valid_3), 0);
        end
        tick();
        req_valid = 2'b11;
        @(negedge clk);
        chk("rw_grant_after_reset", 32'(req_ready_3), 1);
        tick();
        req_valid = 2'b00;
        for (int c = 0; c < LAT3 + 3; c++) tick();

        // Randomized run against the transaction-level model
        do_reset();
        m_act = 1'b0; m_ptr = 1'b0; m_own = 1'b0; m_cm = 1'b0; m_cd = 8'h00;
        m_last_d = 8'h00; m_last_s = 5'h00; m_at = 0; m_op = 8'h00; m_res = 8'h00; m_st = 5'h00;
        for (int i = 0; i < 600; i++) begin
            tick();
            req_valid  = 2'($urandom);
            req_mode   = 2'($urandom);
            req_data0  = 8'($urandom);
            req_data1  = 8'($urandom);
            resp_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            @(negedge clk);
            e_rdy = 2'b00;
            e_rv  = 2'b00;
            w     = 1'b0;
            if (!m_act) begin
                if (req_valid != 2'b00) begin
                    w = (req_valid == 2'b11) ? m_ptr : req_valid[1];
                    e_rdy = w ? 2'b10 : 2'b01;
                end
            end else if (i >= m_at) begin
                e_rv = m_own ? 2'b10 : 2'b01;
                m_last_d = m_res;
                m_last_s = m_st;
            end
            chk("rnd_req_ready", 32'(req_ready), 32'(e_rdy));
            chk("rnd_resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("rnd_busy", 32'(busy), 32'(m_act));
            chk("rnd_resp_data", 32'(resp_data), 32'(m_last_d));
            chk("rnd_resp_status", 32'(resp_status), 32'(m_last_s));
            chk("rnd_codec_data", 32'(codec_data), 32'(m_cd));
            chk("rnd_codec_mode", 32'(codec_mode), 32'(m_cm));
            if (!m_act && req_valid != 2'b00) begin
                m_act = 1'b1;
                m_own = w;
                m_cm  = req_mode[w];
                m_op  = w ? req_data1 : req_data0;
                if (!m_cm) m_op = m_op % 16;
                m_cd  = m_op;
                m_res = ~m_op;
                m_st  = m_cm ? {m_op[2:0], m_op[4:3]} : 5'h00;
                m_at  = i + 1 + LAT;
            end else if (m_act && i >= m_at && resp_ready[m_own]) begin
                m_act = 1'b0;
                m_ptr = ~m_own;
            end
        end
        tick();
        req_valid = 2'b00; resp_ready = 2'b11;
        for (int c = 0; c < LAT3 + 3; c++) tick();

`ifdef HAMMING_ARB_STATS_EN
        do_reset();
        @(negedge clk);
        chk("stat_rst_single", 32'(stat_single), 0);
        chk("stat_rst_double", 32'(stat_double), 0);
        tick();
        run_jobs(200, 8'h08);
        @(negedge clk);
        chk("stat_single_200", 32'(stat_single), 200);
        tick();
        run_jobs(60, 8'h08);
        @(negedge clk);
        chk("stat_single_sat", 32'(stat_single), 255);
        chk("stat_double_zero", 32'(stat_double), 0);
        tick();
        run_jobs(2, 8'h10);
        run_jobs(1, 8'h18);
        @(negedge clk);
        chk("stat_double_cnt", 32'(stat_double), 3);
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        @(negedge clk);
        chk("stat_clr_single", 32'(stat_single), 0);
        chk("stat_clr_double", 32'(stat_double), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
